// File: rtl/mac_vector.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : mac_vector
//  Purpose  : Multi-lane two-stage pipelined multiply-accumulate unit with
//             saturating accumulation, framed by first/last markers, and a
//             rounded, scaled, saturated registered output per lane.
//  Revision : 1.0  - initial release
// ============================================================================
module mac_vector #(
    parameter int LANES             = 4,
    parameter int A_WIDTH           = 16,
    parameter int B_WIDTH           = 16,
    parameter int ACCUMULATOR_WIDTH = 32,
    parameter int OUTPUT_WIDTH      = 16,
    parameter int OUTPUT_SCALE      = 0,
    parameter int ROUND             = 0
) (
    input  logic                            clk,
    input  logic                            arst_n_in,
    input  logic                            in_valid,
    input  logic                            in_first,
    input  logic                            in_last,
    input  logic [LANES*A_WIDTH-1:0]        a,
    input  logic [LANES*B_WIDTH-1:0]        b,
    output logic [LANES*OUTPUT_WIDTH-1:0]   out,
    output logic                            out_valid,
    output logic [LANES-1:0]                ovf
);

    localparam int PROD_WIDTH = A_WIDTH + B_WIDTH;
    localparam int SUM_WIDTH  = ACCUMULATOR_WIDTH + 1;
    localparam int RND_SHIFT  = (OUTPUT_SCALE > 0) ? (OUTPUT_SCALE - 1) : 0;

    // Rounding bias: half an output LSB, only when rounding a non-zero shift.
    localparam logic signed [SUM_WIDTH-1:0] RND =
        ((ROUND != 0) && (OUTPUT_SCALE > 0)) ? (SUM_WIDTH'(1) << RND_SHIFT)
                                             : '0;

    localparam logic signed [ACCUMULATOR_WIDTH-1:0] ACC_MAX =
        {1'b0, {(ACCUMULATOR_WIDTH-1){1'b1}}};
    localparam logic signed [ACCUMULATOR_WIDTH-1:0] ACC_MIN =
        {1'b1, {(ACCUMULATOR_WIDTH-1){1'b0}}};
    localparam logic signed [OUTPUT_WIDTH-1:0] OUT_MAX =
        {1'b0, {(OUTPUT_WIDTH-1){1'b1}}};
    localparam logic signed [OUTPUT_WIDTH-1:0] OUT_MIN =
        {1'b1, {(OUTPUT_WIDTH-1){1'b0}}};

    // Stage-1 control, shared by every lane.
    logic v1;
    logic f1;
    logic l1;

    // Stage-1 control register; first/last are only meaningful on a valid beat.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            v1        <= 1'b0;
            f1        <= 1'b0;
            l1        <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            v1        <= in_valid;
            f1        <= in_valid & in_first;
            l1        <= in_valid & in_last;
            out_valid <= v1 & l1;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic signed [A_WIDTH-1:0]           a_lane;
        logic signed [B_WIDTH-1:0]           b_lane;
        logic signed [PROD_WIDTH-1:0]        prod;
        logic signed [ACCUMULATOR_WIDTH-1:0] prod_sat;
        logic                                prod_ovf;
        logic signed [ACCUMULATOR_WIDTH-1:0] p;
        logic                                p_ovf;
        logic signed [ACCUMULATOR_WIDTH-1:0] acc;
        logic signed [ACCUMULATOR_WIDTH-1:0] acc_in;
        logic signed [SUM_WIDTH-1:0]         sum;
        logic signed [ACCUMULATOR_WIDTH-1:0] sat_sum;
        logic                                sum_ovf;
        logic signed [SUM_WIDTH-1:0]         rounded;
        logic signed [SUM_WIDTH-1:0]         shifted;
        logic signed [OUTPUT_WIDTH-1:0]      out_sat;
        logic                                out_ovf;
        logic signed [OUTPUT_WIDTH-1:0]      out_q;
        logic                                ovf_q;

        assign a_lane = a[i*A_WIDTH +: A_WIDTH];
        assign b_lane = b[i*B_WIDTH +: B_WIDTH];
        assign prod   = a_lane * b_lane;

        if (PROD_WIDTH > ACCUMULATOR_WIDTH) begin : g_prod_sat
            logic [PROD_WIDTH-ACCUMULATOR_WIDTH:0] prod_top;
            assign prod_top = prod[PROD_WIDTH-1:ACCUMULATOR_WIDTH-1];
            // Product fits only if all bits above the accumulator MSB match it.
            always_comb begin
                prod_ovf = !((&prod_top) || !(|prod_top));
                prod_sat = prod[ACCUMULATOR_WIDTH-1:0];
                if (prod_ovf) begin
                    prod_sat = prod[PROD_WIDTH-1] ? ACC_MIN : ACC_MAX;
                end
            end
        end else begin : g_prod_ext
            assign prod_ovf = 1'b0;
            assign prod_sat = ACCUMULATOR_WIDTH'(prod);
        end

        // Stage-1 product register; holds across bubbles.
        always_ff @(posedge clk or negedge arst_n_in) begin
            if (!arst_n_in) begin
                p     <= '0;
                p_ovf <= 1'b0;
            end else if (in_valid) begin
                p     <= prod_sat;
                p_ovf <= prod_ovf;
            end
        end

        // A first beat starts from zero instead of the held accumulator.
        assign acc_in = f1 ? '0 : acc;
        assign sum    = SUM_WIDTH'(p) + SUM_WIDTH'(acc_in);

        // Saturate the one-bit-wider sum back into the accumulator range.
        always_comb begin
            sum_ovf = (sum[SUM_WIDTH-1] != sum[SUM_WIDTH-2]);
            sat_sum = sum[ACCUMULATOR_WIDTH-1:0];
            if (sum_ovf) begin
                sat_sum = sum[SUM_WIDTH-1] ? ACC_MIN : ACC_MAX;
            end
        end

        assign rounded = SUM_WIDTH'(sat_sum) + RND;
        assign shifted = rounded >>> OUTPUT_SCALE;

        if (OUTPUT_WIDTH < SUM_WIDTH) begin : g_out_sat
            logic [SUM_WIDTH-OUTPUT_WIDTH:0] out_top;
            assign out_top = shifted[SUM_WIDTH-1:OUTPUT_WIDTH-1];
            // Clamp the scaled value into the signed output range.
            always_comb begin
                out_ovf = !((&out_top) || !(|out_top));
                out_sat = shifted[OUTPUT_WIDTH-1:0];
                if (out_ovf) begin
                    out_sat = shifted[SUM_WIDTH-1] ? OUT_MIN : OUT_MAX;
                end
            end
        end else begin : g_out_ext
            assign out_ovf = 1'b0;
            assign out_sat = OUTPUT_WIDTH'(shifted);
        end

        // Stage-2 accumulate, sticky overflow and output register.
        always_ff @(posedge clk or negedge arst_n_in) begin
            if (!arst_n_in) begin
                acc   <= '0;
                ovf_q <= 1'b0;
                out_q <= '0;
            end else if (v1) begin
                acc   <= sat_sum;
                ovf_q <= (ovf_q & ~f1) | p_ovf | sum_ovf | (l1 & out_ovf);
                if (l1) begin
                    out_q <= out_sat;
                end
            end
        end

        assign out[i*OUTPUT_WIDTH +: OUTPUT_WIDTH] = out_q;
        assign ovf[i]                              = ovf_q;
    end

endmodule
`default_nettype wire
